crc_frame_engine: RTL
=====================

Name: crc_frame_engine

Overview:
- Parametrised CRC engine for the MAC TX/RX paths. Successor to the single-byte, fixed-mode CRC unit.
- Processes DATA_WIDTH/8 byte lanes per clock, with partial last beats via byte enables.
- Supports reflected and non-reflected algorithms, seed and final XOR, and frame start/end framing.
- RX-side frame-check (residue) output is available as an optional feature.

Parameters:
- CRC_WIDTH, 32, width of the CRC register (8..32).
- DATA_WIDTH, 32, data bus width; multiple of 8, 8..64.
- POLYNOMIAL, 32'h04C11DB7, generator polynomial in normal (MSB-first) form, low CRC_WIDTH bits used.
- SEED, 32'hFFFFFFFF, register value loaded on start.
- XOROUT, 32'hFFFFFFFF, value XORed onto crc_out.
- REFLECT, 1, 1 = bytes LSB-first and output reflected (Ethernet); 0 = MSB-first, no reflection.
- RESIDUE, 32'hDEBB20E3, expected internal register value after data+FCS (CRC_CHECK_EN only).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  frame start; loads SEED. May coincide with the first data beat.
- data_in  in  DATA_WIDTH  beat data; lane 0 = bits[7:0], processed first.
- data_valid  in  1  beat qualifier.
- data_be  in  DATA_WIDTH/8  byte enables; must be contiguous from lane 0; all ones except on the last beat.
- last  in  1  final beat of frame; valid only with data_valid.
- crc_out  out  CRC_WIDTH  running CRC with reflection and XOROUT applied.
- crc_valid  out  1  one-cycle pulse: crc_out is the final frame CRC.
- crc_ok  out  1  residue match, qualified by crc_valid.
- busy  out  1  frame in progress (ACTIVE state).
- err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset state:
  - State IDLE.
  - Internal register = SEED; crc_out = (SEED, reflected if REFLECT) ^ XOROUT.
  - crc_valid, crc_ok, busy, err = 0.
- State machine: IDLE, ACTIVE, DONE.
  - IDLE: start -> ACTIVE (register = SEED). With start && data_valid in the same cycle, the beat is folded into SEED in that cycle. If that beat also has last, go straight to DONE.
  - ACTIVE: each data_valid beat folds the enabled bytes, lanes in ascending order. data_valid && last -> DONE.
  - DONE: lasts one cycle. crc_valid=1, and crc_ok is valid. Then -> IDLE. start in DONE is honoured exactly as in IDLE, so back-to-back frames have zero gap.
- Latency:
  - The register and crc_out update on the clock edge after an accepted beat.
  - crc_valid asserts the cycle after the last beat.
- Byte enables:
  - Disabled lanes leave the register untouched.
  - data_be = 0 with data_valid: no update. If last is also set, the frame still ends.
  - Non-contiguous data_be: err pulses, and only lanes below the first zero are processed.
- Protocol violations:
  - data_valid in IDLE without start: beat ignored, err pulses.
  - start in ACTIVE: frame aborted, register reloaded to SEED (with any same-cycle beat folded in), err pulses, state stays ACTIVE. No crc_valid for the aborted frame.
- Arithmetic:
  - Bitwise LFSR unrolled combinationally over all lanes per cycle: no multi-cycle iteration, no table ROM.
  - REFLECT=1: each byte is consumed LSB-first; the register is bit-reversed before XOROUT.
- crc_out holds its value while idle. It changes only on beats, start, or reset.
- reset mid-frame: immediate return to the reset state. No crc_valid, no err.

Optional Feature:
- Macro: CRC_CHECK_EN.
- Defined:
  - In DONE, crc_ok = (internal register, before reflection/XOROUT) == RESIDUE[CRC_WIDTH-1:0].
  - Registered together with crc_valid.
- Undefined:
  - crc_ok tied to 0, comparator removed, RESIDUE unused.

Test Plan:
1. DATA_WIDTH=8, REFLECT=0, SEED=0, XOROUT=0, POLYNOMIAL=04C11DB7:
   - start+beat 8'hAA with last -> crc_valid next cycle, crc_out=32'hDEA580D8.
   - Continuing a 2-byte frame AA,AA -> final crc_out=32'h5630B33B.
2. Default Ethernet parameters, DATA_WIDTH=32:
   - Bytes "123456789" as beats 32'h34333231, 32'h38373635, 32'h00000039 with data_be=4'b0001 and last -> crc_out=32'hCBF43926, crc_valid 1 cycle.
3. CRC_CHECK_EN defined:
   - Same 9 bytes followed by FCS bytes 26,39,F4,CB (13 bytes, last beat data_be=4'b0001) -> crc_ok=1.
   - Corrupt one FCS byte -> crc_ok=0.
4. Back-to-back frames:
   - start asserted in the DONE cycle with a new first beat -> no bubble.
   - Second frame's CRC is independent of the first (repeat test 2 result 32'hCBF43926).
5. Violations:
   - data_valid in IDLE -> err pulse, crc_out unchanged.
   - start mid-frame -> err pulse; the restarted frame yields the correct CRC.
   - data_be=4'b0101 -> err pulse.
6. reset asserted mid-frame:
   - Next cycle busy=0, crc_valid=0, crc_out=32'h00000000 (SEED^XOROUT with defaults).
   - A subsequent frame computes correctly.

Source files
------------

// File: rtl/crc_frame_engine.sv
// crc_frame_engine: multi-lane LFSR CRC engine with start/last framing.
// Define CRC_CHECK_EN to build the RX residue comparator driving crc_ok.
module crc_frame_engine #(
    parameter int          CRC_WIDTH  = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] POLYNOMIAL = 32'h04C11DB7,
    parameter logic [31:0] SEED       = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT    = 1'b1,
    parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    input  logic [DATA_WIDTH/8-1:0] data_be,
    input  logic                    last,
    output logic [CRC_WIDTH-1:0]    crc_out,
    output logic                    crc_valid,
    output logic                    crc_ok,
    output logic                    busy,
    output logic                    err
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [CRC_WIDTH-1:0] POLY   = POLYNOMIAL[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] SEED_W = SEED[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] XOR_W  = XOROUT[CRC_WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CRC_WIDTH-1:0] base, folded;
    logic [LANES-1:0]     lane_en;
    logic                 run;
    logic                 noncontig;
    logic                 accept;
    logic                 err_q, err_d;

    function automatic logic [CRC_WIDTH-1:0] rev_crc(
        input logic [CRC_WIDTH-1:0] v
    );
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = v[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    // Register is kept MSB-first; reflected bytes are bit-swapped on entry.
    function automatic logic [CRC_WIDTH-1:0] fold_byte(
        input logic [CRC_WIDTH-1:0] c,
        input logic [7:0]           b
    );
        logic [CRC_WIDTH-1:0] r;
        logic [7:0]           bb;
        logic                 fb;
        for (int i = 0; i < 8; i++) begin
            bb[i] = REFLECT ? b[7-i] : b[i];
        end
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_WIDTH-1] ^ bb[i];
            r  = {r[CRC_WIDTH-2:0], 1'b0};
            if (fb) begin
                r = r ^ POLY;
            end
        end
        return r;
    endfunction

    // Only the contiguous run of enables starting at lane 0 is honoured.
    always_comb begin
        lane_en = '0;
        run     = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            run        = run & data_be[i];
            lane_en[i] = run;
        end
    end

    assign noncontig = (data_be != lane_en);
    assign accept    = data_valid && (start || state_q == ACTIVE);

    always_comb begin
        base   = start ? SEED_W : crc_q;
        folded = base;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                folded = fold_byte(folded, data_in[8*i +: 8]);
            end
        end
        crc_d = accept ? folded : base;
    end

    always_comb begin
        state_d = state_q;
        err_d   = accept && noncontig;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (data_valid && last) ? DONE : ACTIVE;
                end else begin
                    state_d = IDLE;
                    if (data_valid) begin
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (data_valid && last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= SEED_W;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
        end
    end

`ifdef CRC_CHECK_EN
    logic                 ok_q;
    logic [CRC_WIDTH-1:0] chk_view;

    // Residues are quoted in the algorithm's own bit order.
    assign chk_view = REFLECT ? rev_crc(crc_d) : crc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ok_q <= 1'b0;
        end else begin
            ok_q <= (state_d == DONE) &&
                    (chk_view == RESIDUE[CRC_WIDTH-1:0]);
        end
    end

    assign crc_ok = ok_q;
`else
    assign crc_ok = 1'b0;
`endif

    assign crc_out   = (REFLECT ? rev_crc(crc_q) : crc_q) ^ XOR_W;
    assign crc_valid = (state_q == DONE);
    assign busy      = (state_q == ACTIVE);
    assign err       = err_q;

endmodule
